fetch_decode_alu: RTL and testbench

FETCH_DECODE_ALU -- requirements
Module: fetch_decode_alu

---
 rtl/fetch_decode_alu.sv | 140 ++++++++++++++
 tb/tb_fetch_decode_alu.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_alu.sv
// Single-cycle IR, decoder, immediate extender and ALU for a MIPS-like subset.
// Ports: clk/rst_n, ir_load+inst_in capture, rs/rt data in; IR fields, controls, alu_out, zf out.
module fetch_decode_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_load,
  input  logic [31:0] inst_in,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] inst,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [25:0] imm26,
  output logic [31:0] imm_ext,
  output logic [3:0]  alu_ctr,
  output logic        reg_dst,
  output logic        reg_wrt,
  output logic        mem_read,
  output logic        mem_wrt,
  output logic        mem_reg,
  output logic        alu_src,
  output logic        branch,
  output logic        jump,
  output logic [31:0] alu_out,
  output logic        zf
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_r;
  logic [31:0] opb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       inst <= 32'h0;
    else if (ir_load) inst <= inst_in;
  end

  assign op    = inst[31:26];
  assign funct = inst[5:0];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign imm16 = inst[15:0];
  assign imm26 = inst[25:0];
  assign is_r  = (op == OP_R);

  // Logical immediates zero-extend; everything else sign-extends.
  assign imm_ext = (op == OP_ANDI || op == OP_ORI)
                 ? {16'h0, imm16}
                 : {{16{imm16[15]}}, imm16};

  always_comb begin
    alu_ctr  = ALU_ADD;
    reg_dst  = 1'b0;
    reg_wrt  = 1'b0;
    mem_read = 1'b0;
    mem_wrt  = 1'b0;
    mem_reg  = 1'b0;
    alu_src  = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    unique case (1'b1)
      is_r && funct == 6'b100000: begin
        alu_ctr = ALU_ADD; reg_dst = 1'b1; reg_wrt = 1'b1;
      end
      is_r && funct == 6'b100010: begin
        alu_ctr = ALU_SUB; reg_dst = 1'b1; reg_wrt = 1'b1;
      end
      is_r && funct == 6'b100100: begin
        alu_ctr = ALU_AND; reg_dst = 1'b1; reg_wrt = 1'b1;
      end
      is_r && funct == 6'b100101: begin
        alu_ctr = ALU_OR;  reg_dst = 1'b1; reg_wrt = 1'b1;
      end
      is_r && funct == 6'b101010: begin
        alu_ctr = ALU_SLT; reg_dst = 1'b1; reg_wrt = 1'b1;
      end
      is_r && funct == 6'b100111: begin
        alu_ctr = ALU_NOR; reg_dst = 1'b1; reg_wrt = 1'b1;
      end
      op == OP_LW: begin
        alu_src = 1'b1; reg_wrt = 1'b1;
        mem_read = 1'b1; mem_reg = 1'b1;
      end
      op == OP_SW: begin
        alu_src = 1'b1; mem_wrt = 1'b1;
      end
      op == OP_BEQ: begin
        alu_ctr = ALU_SUB; branch = 1'b1;
      end
      op == OP_ADDI: begin
        alu_src = 1'b1; reg_wrt = 1'b1;
      end
      op == OP_ANDI: begin
        alu_ctr = ALU_AND; alu_src = 1'b1; reg_wrt = 1'b1;
      end
      op == OP_ORI: begin
        alu_ctr = ALU_OR; alu_src = 1'b1; reg_wrt = 1'b1;
      end
      op == OP_J: jump = 1'b1;
      default: ;
    endcase
  end

  assign opb = alu_src ? imm_ext : rt_data;

  always_comb begin
    alu_out = 32'h0;
    unique case (alu_ctr)
      ALU_AND: alu_out = rs_data & opb;
      ALU_OR:  alu_out = rs_data | opb;
      ALU_ADD: alu_out = rs_data + opb;
      ALU_SUB: alu_out = rs_data - opb;
      ALU_SLT: alu_out = {31'h0, $signed(rs_data) < $signed(opb)};
      ALU_NOR: alu_out = ~(rs_data | opb);
      default: alu_out = 32'h0;
    endcase
  end

  assign zf = (alu_out == 32'h0);

endmodule

// File: tb/tb_fetch_decode_alu.sv
// Directed bench for fetch_decode_alu.
// Loads hand-picked instructions and compares IR fields, controls and ALU.
module tb_fetch_decode_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ir_load;
  logic [31:0] inst_in, rs_data, rt_data;
  logic [31:0] inst, imm_ext, alu_out;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [3:0]  alu_ctr;
  logic        reg_dst, reg_wrt, mem_read, mem_wrt;
  logic        mem_reg, alu_src, branch, jump, zf;
  logic [7:0]  ctl;

  int errors = 0;
  int checks = 0;

  fetch_decode_alu dut (
    .clk(clk), .rst_n(rst_n), .ir_load(ir_load),
    .inst_in(inst_in), .rs_data(rs_data), .rt_data(rt_data),
    .inst(inst), .rs(rs), .rt(rt), .rd(rd),
    .imm16(imm16), .imm26(imm26), .imm_ext(imm_ext),
    .alu_ctr(alu_ctr), .reg_dst(reg_dst), .reg_wrt(reg_wrt),
    .mem_read(mem_read), .mem_wrt(mem_wrt), .mem_reg(mem_reg),
    .alu_src(alu_src), .branch(branch), .jump(jump),
    .alu_out(alu_out), .zf(zf)
  );

  always #5 clk = ~clk;

  // {reg_dst,reg_wrt,mem_read,mem_wrt,mem_reg,alu_src,branch,jump}
  assign ctl = {reg_dst, reg_wrt, mem_read, mem_wrt,
                mem_reg, alu_src, branch, jump};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] w);
    @(negedge clk);
    inst_in = w;
    ir_load = 1'b1;
    @(posedge clk);
    #1;
    ir_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ir_load = 1'b0; inst_in = 32'h0;
    rs_data = 32'd3; rt_data = 32'd4;
    #2;
    chk("rst_inst", inst, 32'h0);
    chk("rst_ctl", {24'h0, ctl}, 32'h0);
    chk("rst_aluctr", {28'h0, alu_ctr}, 32'h2);
    chk("rst_aluout", alu_out, 32'd7);
    chk("rst_zf", {31'h0, zf}, 32'h0);
    chk("rst_imm", imm_ext, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // sub $1,$2,$3
    rs_data = 32'd5; rt_data = 32'd5;
    load(32'h00430822);
    chk("sub_rs", {27'h0, rs}, 32'd2);
    chk("sub_rt", {27'h0, rt}, 32'd3);
    chk("sub_rd", {27'h0, rd}, 32'd1);
    chk("sub_ctl", {24'h0, ctl}, 32'hC0);
    chk("sub_aluctr", {28'h0, alu_ctr}, 32'h6);
    chk("sub_aluout", alu_out, 32'h0);
    chk("sub_zf", {31'h0, zf}, 32'h1);

    // async reset mid-cycle, overriding a pending load
    @(negedge clk);
    inst_in = 32'h8C41FFFC; ir_load = 1'b1;
    rs_data = 32'd3; rt_data = 32'd4;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_inst", inst, 32'h0);
    chk("arst_ctl", {24'h0, ctl}, 32'h0);
    chk("arst_aluout", alu_out, 32'd7);
    @(posedge clk);
    #1;
    chk("arst_hold", inst, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; ir_load = 1'b0;

    // lw: sign-extended negative offset
    rs_data = 32'h100;
    load(32'h8C41FFFC);
    chk("lw_imm", imm_ext, 32'hFFFFFFFC);
    chk("lw_ctl", {24'h0, ctl}, 32'h6C);
    chk("lw_aluout", alu_out, 32'hFC);

    // ori: zero-extended
    rs_data = 32'h0;
    load(32'h3441FFFF);
    chk("ori_imm", imm_ext, 32'h0000FFFF);
    chk("ori_ctl", {24'h0, ctl}, 32'h44);
    chk("ori_aluctr", {28'h0, alu_ctr}, 32'h1);
    chk("ori_aluout", alu_out, 32'h0000FFFF);

    // slt signed: -1 < 1
    rs_data = 32'hFFFFFFFF; rt_data = 32'd1;
    load(32'h0043082A);
    chk("slt_aluctr", {28'h0, alu_ctr}, 32'h7);
    chk("slt_lt", alu_out, 32'd1);
    rs_data = 32'd1; rt_data = 32'hFFFFFFFF;
    #1;
    chk("slt_ge", alu_out, 32'd0);
    chk("slt_zf", {31'h0, zf}, 32'h1);

    // andi with high bit set in imm
    rs_data = 32'hFFFFFFFF;
    load(32'h3041F0F0);
    chk("andi_imm", imm_ext, 32'h0000F0F0);
    chk("andi_aluout", alu_out, 32'h0000F0F0);

    // nor
    rs_data = 32'hF0F0F0F0; rt_data = 32'h0F0F0000;
    load(32'h00430827);
    chk("nor_aluctr", {28'h0, alu_ctr}, 32'hC);
    chk("nor_aluout", alu_out, 32'h00000F0F);

    // beq equal operands
    rs_data = 32'd9; rt_data = 32'd9;
    load(32'h10430005);
    chk("beq_ctl", {24'h0, ctl}, 32'h02);
    chk("beq_imm", imm_ext, 32'h5);
    chk("beq_zf", {31'h0, zf}, 32'h1);

    // sw
    rs_data = 32'h200;
    load(32'hAC41FFFC);
    chk("sw_ctl", {24'h0, ctl}, 32'h14);
    chk("sw_aluout", alu_out, 32'h1FC);

    // unlisted funct decodes as NOP
    rs_data = 32'd2; rt_data = 32'd3;
    load(32'h00430821);
    chk("badfn_ctl", {24'h0, ctl}, 32'h0);
    chk("badfn_aluout", alu_out, 32'd5);

    // jump then hold
    load(32'h08000010);
    chk("j_ctl", {24'h0, ctl}, 32'h01);
    chk("j_imm26", {6'h0, imm26}, 32'h10);
    chk("j_aluctr", {28'h0, alu_ctr}, 32'h2);
    @(negedge clk);
    inst_in = 32'hFFFFFFFF; ir_load = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_inst", inst, 32'h08000010);

    // illegal opcode, add wraps
    rs_data = 32'h7FFFFFFF; rt_data = 32'd1;
    load(32'hFC000000);
    chk("ill_ctl", {24'h0, ctl}, 32'h0);
    chk("ill_aluctr", {28'h0, alu_ctr}, 32'h2);
    chk("ill_aluout", alu_out, 32'h80000000);
    chk("ill_zf", {31'h0, zf}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
